bird_physics: RTL and testbench

- Produces `bird_y` for `game_controller`, which consumes it for collision checks and rendering.
- Converts a raw flap button into per-frame gravity/flap motion, gated by the 2-bit game `state` that `game_controller` outputs.
- Fixed-rate physics frames come from an internal clock divider; position is clamped to the screen.

---
 rtl/flappy_pkg.sv | 20 ++
 rtl/frame_divider.sv | 34 +++
 rtl/bird_physics.sv | 132 +++++++++++++
 tb/tb_bird_physics.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared game-wide definitions used by bird_physics, game_controller and
// any other block that needs the screen geometry or the game state encoding.
package flappy_pkg;

  // Game state as driven by game_controller; 2'b11 is never produced and
  // consumers treat it like GAME_OVER.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    PLAYING   = 2'b01,
    GAME_OVER = 2'b10
  } game_state_t;

  localparam int SCREEN_HEIGHT = 480;
  localparam int BIRD_HEIGHT   = 20;
  localparam int BIRD_X        = 100;

  // Bits needed to address a screen row.
  localparam int CORDH = $clog2(SCREEN_HEIGHT);

endpackage

// File: rtl/frame_divider.sv
// Free-running divider that produces a one-cycle tick every TICK_DIV clocks.
// The counter is parked at zero while disabled, so the first tick after
// enabling always arrives exactly TICK_DIV cycles later. The tick output is
// combinational on the terminal count so the consumer can act in that cycle.
module frame_divider #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Count 0..TICK_DIV-1 and wrap; hold at zero when disabled or in reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/bird_physics.sv
// Vertical motion of the bird: gravity, flap impulses and screen clamping,
// stepped once per physics frame while the game is PLAYING.
module bird_physics #(
  parameter int SCREEN_HEIGHT = flappy_pkg::SCREEN_HEIGHT,
  parameter int BIRD_HEIGHT   = flappy_pkg::BIRD_HEIGHT,
  parameter int START_Y       = 240,
  parameter int TICK_DIV      = 833333,
  parameter int GRAVITY       = 1,
  parameter int FLAP_VEL      = -8,
  parameter int MAX_FALL_VEL  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        state,
  input  logic              flap_button,
  output logic [9:0]        bird_y,
  output logic signed [5:0] velocity,
  output logic              frame_tick,
  output logic              hit_floor,
  output logic              hit_ceiling
);

  import flappy_pkg::*;

  localparam int Y_MAX = SCREEN_HEIGHT - BIRD_HEIGHT;

  // Motion math is done at 12 bits signed so that an upward step from near
  // the top can go negative and a downward step can overshoot Y_MAX.
  localparam logic signed [11:0] Y_MAX_S    = 12'(Y_MAX);
  localparam logic signed [11:0] FLAP_S     = 12'(FLAP_VEL);
  localparam logic signed [11:0] GRAVITY_S  = 12'(GRAVITY);
  localparam logic signed [11:0] MAX_FALL_S = 12'(MAX_FALL_VEL);

  game_state_t       mode;
  logic              flap_prev;
  logic              flap_pending;
  logic              flap_pulse;
  logic              update;
  logic signed [11:0] vel_ext;
  logic signed [11:0] vel_inc;
  logic signed [11:0] v_new;
  logic signed [11:0] y_new;

  // Fold the raw 2-bit state onto the three game states; the unused code
  // behaves like GAME_OVER.
  always_comb begin
    mode = GAME_OVER;
    case (state)
      2'b00:   mode = IDLE;
      2'b01:   mode = PLAYING;
      default: mode = GAME_OVER;
    endcase
  end

  assign flap_pulse = flap_button & ~flap_prev;

  // Counter runs in PLAYING and GAME_OVER, parked in IDLE.
  frame_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_frame_divider (
    .clk   (clk),
    .reset (reset),
    .enable(mode != IDLE),
    .tick  (update)
  );

  // Candidate velocity and position for this frame; a flap arriving in the
  // update cycle itself counts as pending.
  always_comb begin
    vel_ext = {{6{velocity[5]}}, velocity};
    vel_inc = vel_ext + GRAVITY_S;
    v_new   = vel_inc;
    if (flap_pending || flap_pulse) begin
      v_new = FLAP_S;
    end else if (vel_inc > MAX_FALL_S) begin
      v_new = MAX_FALL_S;
    end
    y_new = $signed({2'b00, bird_y}) + v_new;
  end

  // Per-state register updates; frame_tick and hit_ceiling are strobes that
  // default low every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bird_y       <= 10'(START_Y);
      velocity     <= '0;
      frame_tick   <= 1'b0;
      hit_floor    <= 1'b0;
      hit_ceiling  <= 1'b0;
      flap_prev    <= 1'b0;
      flap_pending <= 1'b0;
    end else begin
      flap_prev   <= flap_button;
      frame_tick  <= 1'b0;
      hit_ceiling <= 1'b0;
      case (mode)
        IDLE: begin
          bird_y       <= 10'(START_Y);
          velocity     <= '0;
          flap_pending <= 1'b0;
          hit_floor    <= 1'b0;
        end
        PLAYING: begin
          if (update) begin
            flap_pending <= 1'b0;
            frame_tick   <= 1'b1;
            if (y_new < 12'sd0) begin
              bird_y      <= '0;
              velocity    <= '0;
              hit_ceiling <= 1'b1;
              hit_floor   <= 1'b0;
            end else if (y_new > Y_MAX_S) begin
              bird_y    <= 10'(Y_MAX);
              velocity  <= '0;
              hit_floor <= 1'b1;
            end else begin
              bird_y    <= y_new[9:0];
              velocity  <= v_new[5:0];
              hit_floor <= 1'b0;
            end
          end else if (flap_pulse) begin
            flap_pending <= 1'b1;
          end
        end
        default: begin
          flap_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bird_physics.sv
// Bench for bird_physics: directed scenarios plus a randomized run, every
// cycle compared against a frame-level reference model of the bird's motion.
module tb_bird_physics;

  localparam int TDIV    = 4;
  localparam int Y_MAX   = 460;
  localparam int START   = 240;
  localparam int FLAPV   = -8;
  localparam int MAXFALL = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        state;
  logic              flap_button;
  logic [9:0]        bird_y;
  logic signed [5:0] velocity;
  logic              frame_tick;
  logic              hit_floor;
  logic              hit_ceiling;

  logic              reset2;
  logic [1:0]        state2;
  logic              flap2;
  logic [9:0]        bird_y2;
  logic signed [5:0] velocity2;
  logic              frame_tick2;
  logic              hit_floor2;
  logic              hit_ceiling2;

  int checks = 0;
  int errors = 0;

  int m_y, m_v, m_phase;
  bit m_prev, m_pend, m_ft, m_hf, m_hc;

  int y_hist[$];
  int v_hist[$];
  int hf_hist[$];

  always #5 clk = ~clk;

  bird_physics #(.TICK_DIV(TDIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .state      (state),
    .flap_button(flap_button),
    .bird_y     (bird_y),
    .velocity   (velocity),
    .frame_tick (frame_tick),
    .hit_floor  (hit_floor),
    .hit_ceiling(hit_ceiling)
  );

  bird_physics #(.TICK_DIV(TDIV), .START_Y(4)) dut_top (
    .clk        (clk),
    .reset      (reset2),
    .state      (state2),
    .flap_button(flap2),
    .bird_y     (bird_y2),
    .velocity   (velocity2),
    .frame_tick (frame_tick2),
    .hit_floor  (hit_floor2),
    .hit_ceiling(hit_ceiling2)
  );

  task automatic check_output(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: one frame of motion every TDIV clocks spent outside IDLE.
  task automatic model_cycle(input bit rst, input bit [1:0] st, input bit flap);
    bit pulse;
    int nv, ny;
    if (!rst) begin
      m_y = START; m_v = 0; m_phase = 0;
      m_prev = 0; m_pend = 0; m_ft = 0; m_hf = 0; m_hc = 0;
      return;
    end
    pulse  = flap && !m_prev;
    m_prev = flap;
    m_ft   = 0;
    m_hc   = 0;
    if (st == 2'b00) begin
      m_y = START; m_v = 0; m_pend = 0; m_hf = 0; m_phase = 0;
      return;
    end
    m_phase++;
    if (st == 2'b01) begin
      if (m_phase == TDIV) begin
        nv = (m_pend || pulse) ? FLAPV : ((m_v + 1 > MAXFALL) ? MAXFALL : m_v + 1);
        ny = m_y + nv;
        if (ny < 0) begin
          m_y = 0; m_v = 0; m_hc = 1; m_hf = 0;
        end else if (ny > Y_MAX) begin
          m_y = Y_MAX; m_v = 0; m_hf = 1;
        end else begin
          m_y = ny; m_v = nv; m_hf = 0;
        end
        m_pend = 0;
        m_ft   = 1;
      end else if (pulse) begin
        m_pend = 1;
      end
    end else begin
      m_pend = 0;
    end
    if (m_phase == TDIV) m_phase = 0;
  endtask

  // Drive one clock of stimulus, advance the model, then compare at negedge.
  task automatic apply_stimulus(input bit rst, input bit [1:0] st, input bit flap);
    reset       = rst;
    state       = st;
    flap_button = flap;
    @(posedge clk);
    model_cycle(rst, st, flap);
    @(negedge clk);
    check_output("bird_y", bird_y, m_y);
    check_output("velocity", velocity, m_v);
    check_output("frame_tick", frame_tick, m_ft);
    check_output("hit_floor", hit_floor, m_hf);
    check_output("hit_ceiling", hit_ceiling, m_hc);
    if (m_ft) begin
      y_hist.push_back(int'(bird_y));
      v_hist.push_back(int'(velocity));
      hf_hist.push_back(int'(hit_floor));
    end
  endtask

  task automatic clear_hist();
    y_hist.delete();
    v_hist.delete();
    hf_hist.delete();
  endtask

  initial begin
    int run_len;
    bit [1:0] rs;
    reset2 = 1'b0; state2 = 2'b00; flap2 = 1'b0;
    @(negedge clk);

    $display("[TB] reset and idle");
    apply_stimulus(0, 2'b00, 0);
    apply_stimulus(0, 2'b00, 0);
    check_output("reset_y", bird_y, 240);
    check_output("reset_v", velocity, 0);
    apply_stimulus(1, 2'b00, 0);
    apply_stimulus(1, 2'b00, 0);
    check_output("idle_y", bird_y, 240);
    check_output("idle_tick", frame_tick, 0);

    $display("[TB] free fall");
    clear_hist();
    for (int i = 0; i < 16; i++) apply_stimulus(1, 2'b01, 0);
    check_output("fall_updates", y_hist.size(), 4);
    if (y_hist.size() >= 4) begin
      check_output("fall_y1", y_hist[0], 241);
      check_output("fall_y2", y_hist[1], 243);
      check_output("fall_y3", y_hist[2], 246);
      check_output("fall_y4", y_hist[3], 250);
      check_output("fall_v4", v_hist[3], 4);
    end

    $display("[TB] held flap");
    apply_stimulus(1, 2'b00, 0);
    clear_hist();
    for (int i = 0; i < 12; i++) apply_stimulus(1, 2'b01, 1);
    check_output("flap_updates", y_hist.size(), 3);
    if (y_hist.size() >= 3) begin
      check_output("flap_y1", y_hist[0], 232);
      check_output("flap_v1", v_hist[0], -8);
      check_output("flap_y2", y_hist[1], 225);
      check_output("flap_v2", v_hist[1], -7);
      check_output("flap_y3", y_hist[2], 219);
      check_output("flap_v3", v_hist[2], -6);
    end

    $display("[TB] terminal velocity and floor");
    apply_stimulus(1, 2'b00, 0);
    clear_hist();
    for (int i = 0; i < 28 * TDIV; i++) apply_stimulus(1, 2'b01, 0);
    check_output("floor_updates", y_hist.size(), 28);
    if (y_hist.size() >= 28) begin
      check_output("term_y10", y_hist[9], 295);
      check_output("term_v10", v_hist[9], 10);
      check_output("term_y11", y_hist[10], 305);
      check_output("floor_y", y_hist[26], 460);
      check_output("floor_v", v_hist[26], 0);
      check_output("floor_hf", hf_hist[26], 1);
      check_output("floor_y_again", y_hist[27], 460);
      check_output("floor_hf_again", hf_hist[27], 1);
    end

    $display("[TB] game over freeze, idle, reset mid-play");
    apply_stimulus(1, 2'b00, 0);
    for (int i = 0; i < 10; i++) apply_stimulus(1, 2'b01, 0);
    for (int i = 0; i < 20; i++) apply_stimulus(1, (i % 2) ? 2'b11 : 2'b10, i[0]);
    check_output("freeze_y", bird_y, 243);
    check_output("freeze_v", velocity, 2);
    apply_stimulus(1, 2'b00, 0);
    check_output("back_idle_y", bird_y, 240);
    for (int i = 0; i < 6; i++) apply_stimulus(1, 2'b01, 1);
    apply_stimulus(0, 2'b01, 1);
    check_output("midreset_y", bird_y, 240);
    check_output("midreset_v", velocity, 0);
    check_output("midreset_tick", frame_tick, 0);

    $display("[TB] randomized play");
    for (int blk = 0; blk < 40; blk++) begin
      run_len = $urandom_range(8, 24);
      case ($urandom_range(0, 19))
        0, 1, 2:  rs = 2'b00;
        3, 4:     rs = 2'b10;
        5:        rs = 2'b11;
        default:  rs = 2'b01;
      endcase
      for (int i = 0; i < run_len; i++)
        apply_stimulus($urandom_range(0, 99) != 0, rs, $urandom_range(0, 3) == 0);
    end

    $display("[TB] ceiling clamp");
    reset2 = 1'b1; state2 = 2'b00; flap2 = 1'b0;
    apply_stimulus(1, 2'b00, 0);
    check_output("ceil_start_y", bird_y2, 4);
    state2 = 2'b01; flap2 = 1'b1;
    apply_stimulus(1, 2'b00, 0);
    flap2 = 1'b0;
    apply_stimulus(1, 2'b00, 0);
    apply_stimulus(1, 2'b00, 0);
    check_output("ceil_pre_y", bird_y2, 4);
    check_output("ceil_pre_hc", hit_ceiling2, 0);
    apply_stimulus(1, 2'b00, 0);
    check_output("ceil_y", bird_y2, 0);
    check_output("ceil_v", velocity2, 0);
    check_output("ceil_hc", hit_ceiling2, 1);
    check_output("ceil_tick", frame_tick2, 1);
    apply_stimulus(1, 2'b00, 0);
    check_output("ceil_hc_drop", hit_ceiling2, 0);
    check_output("ceil_y_hold", bird_y2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
